// File: rtl/leitor_tabuleiro.sv
// Snapshots the Sudoku board and streams its cells in index order, counting empty cells.
// Latency: first valido 2 cycles after the iniciar edge; one cell per cycle while pronto=1.
// Backpressure: while valido=1 and pronto=0, dado_saida/indice hold; iniciar outside idle is ignored.
module leitor_tabuleiro #(
    parameter int N       = 4,
    parameter int CELULAS = 81,
    parameter int IW      = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iniciar,
    input  logic [CELULAS*N-1:0] tabuleiro,
    output logic [N-1:0]         dado_saida,
    output logic [IW-1:0]        indice,
    output logic                 valido,
    input  logic                 pronto,
    output logic                 ocupado,
    output logic                 concluido,
    output logic [IW-1:0]        vazias
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CAPTURA = 2'd1,
        ENVIO   = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [IW-1:0] ULTIMO = IW'(CELULAS - 1);
    localparam logic [IW-1:0] TOTAL  = IW'(CELULAS);

    estado_t       estado;
    estado_t       proximo;

    // Private copy of the board so the scan is immune to later register writes.
    logic [N-1:0]  copia [CELULAS];
    logic [IW-1:0] contagem;
    logic [IW-1:0] contagem_mais;
    logic [IW-1:0] indice_prox;

    logic          captura;
    logic          carrega;
    logic          transfere;
    logic          ultimo;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state: capture and finish are single-cycle, streaming ends on the last handshake.
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (iniciar) proximo = CAPTURA;
            CAPTURA: proximo = ENVIO;
            ENVIO:   if (ultimo) proximo = FIM;
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Control strobes: ENVIO with valido low is the first cycle, where cell 0 is loaded.
    always_comb begin
        captura       = (estado == CAPTURA);
        carrega       = (estado == ENVIO) && !valido;
        transfere     = (estado == ENVIO) && valido && pronto;
        ultimo        = transfere && (indice == ULTIMO);
        indice_prox   = indice + 1'b1;
        // Saturating increment so the count can never wrap past the board size.
        contagem_mais = ((dado_saida == '0) && (contagem < TOTAL)) ? contagem + 1'b1 : contagem;
    end

    // Datapath: snapshot, streamed outputs, empty-cell counter and the final report.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CELULAS; i++) begin
                copia[i] <= '0;
            end
            contagem   <= '0;
            dado_saida <= '0;
            indice     <= '0;
            valido     <= 1'b0;
            ocupado    <= 1'b0;
            concluido  <= 1'b0;
            vazias     <= '0;
        end else begin
            concluido <= 1'b0;

            if (captura) begin
                for (int i = 0; i < CELULAS; i++) begin
                    copia[i] <= tabuleiro[i*N +: N];
                end
                contagem <= '0;
                indice   <= '0;
                valido   <= 1'b0;
                ocupado  <= 1'b1;
            end

            if (carrega) begin
                valido     <= 1'b1;
                dado_saida <= copia[0];
            end

            if (transfere) begin
                contagem <= contagem_mais;
                if (ultimo) begin
                    // Count includes the cell handed over on this very edge.
                    valido    <= 1'b0;
                    ocupado   <= 1'b0;
                    concluido <= 1'b1;
                    vazias    <= contagem_mais;
                end else begin
                    indice     <= indice_prox;
                    dado_saida <= copia[indice_prox];
                end
            end
        end
    end

endmodule

// File: tb/tb_leitor_tabuleiro.sv
// Randomized bench for leitor_tabuleiro against a list-based model of the board stream.
// Each scan checks latency, ordering, hold under backpressure, empty-cell count and idle tail.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
module tb_leitor_tabuleiro;

    localparam int N       = 4;
    localparam int CELULAS = 81;
    localparam int IW      = 7;

    logic                 clk;
    logic                 rst;
    logic                 iniciar;
    logic [CELULAS*N-1:0] tabuleiro;
    logic [N-1:0]         dado_saida;
    logic [IW-1:0]        indice;
    logic                 valido;
    logic                 pronto;
    logic                 ocupado;
    logic                 concluido;
    logic [IW-1:0]        vazias;

    int checks;
    int errors;
    int cel [CELULAS];
    int vazias_esp;

    leitor_tabuleiro #(.N(N), .CELULAS(CELULAS), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .iniciar    (iniciar),
        .tabuleiro  (tabuleiro),
        .dado_saida (dado_saida),
        .indice     (indice),
        .valido     (valido),
        .pronto     (pronto),
        .ocupado    (ocupado),
        .concluido  (concluido),
        .vazias     (vazias)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: obtido %0d esperado %0d", tag, obs, esp);
        end
    endtask

    task automatic passo();
        @(posedge clk);
        #1;
    endtask

    // modo: 0 pronto=1, 1 pattern 1,0,0, 2 stall 10 cycles at index 40, 3 random
    task automatic varredura(input int modo, input bit corromper, input int reset_em);
        int  ref_cel [CELULAS];
        int  zeros;
        int  k;
        int  p;
        int  stall;
        bit  fim;
        bit  hold;
        bit  inj;
        logic [N-1:0]  hd;
        logic [IW-1:0] hi;

        ref_cel = cel;
        zeros = 0;
        for (int i = 0; i < CELULAS; i++) begin
            if (ref_cel[i] == 0) zeros++;
            tabuleiro[i*N +: N] = N'(ref_cel[i]);
        end

        iniciar = 1'b1;
        passo();
        iniciar = 1'b0;
        chk("ocupado_antes_captura", ocupado, 0);
        chk("valido_antes_captura", valido, 0);

        k = 0; p = 0; stall = 0; fim = 0; hold = 0; inj = 0;
        hd = '0; hi = '0;
        for (int c = 1; c <= 600 && !fim; c++) begin
            passo();
            iniciar = 1'b0;
            if (hold) begin
                chk("hold_dado", dado_saida, hd);
                chk("hold_indice", indice, hi);
            end
            if (c == 1) chk("valido_captura", valido, 0);
            if (c == 2) begin
                chk("latencia_valido", valido, 1);
                chk("latencia_indice", indice, 0);
                chk("latencia_dado", dado_saida, ref_cel[0]);
            end
            if (concluido) begin
                chk("transferencias", k, CELULAS);
                chk("vazias_final", vazias, zeros);
                chk("ocupado_fim", ocupado, 0);
                chk("valido_fim", valido, 0);
                if (modo == 0) chk("ciclos_ate_concluido", c, CELULAS + 2);
                vazias_esp = zeros;
                fim = 1;
            end else begin
                chk("ocupado_varredura", ocupado, 1);
                chk("vazias_estavel", vazias, vazias_esp);
                if (reset_em >= 0 && valido && k == reset_em) begin
                    chk("indice_antes_reset", indice, reset_em);
                    rst = 1'b1;
                    pronto = 1'b1;
                    passo();
                    rst = 1'b0;
                    pronto = 1'b0;
                    chk("reset_valido", valido, 0);
                    chk("reset_ocupado", ocupado, 0);
                    chk("reset_vazias", vazias, 0);
                    chk("reset_concluido", concluido, 0);
                    vazias_esp = 0;
                    repeat (3) begin
                        passo();
                        chk("reset_sem_concluido", concluido, 0);
                        chk("reset_sem_valido", valido, 0);
                    end
                    return;
                end
                if (corromper && !inj && valido && indice == 20) begin
                    tabuleiro = '1;
                    iniciar = 1'b1;
                    inj = 1;
                end
                case (modo)
                    0: pronto = 1'b1;
                    1: begin pronto = (p % 3 == 0); p++; end
                    2: begin
                        if (valido && indice == 40 && stall < 10) begin
                            pronto = 1'b0;
                            stall++;
                        end else begin
                            pronto = 1'b1;
                        end
                    end
                    default: pronto = 1'($urandom_range(0, 1));
                endcase
                hold = valido && !pronto;
                hd = dado_saida;
                hi = indice;
                if (valido && pronto) begin
                    if (k < CELULAS) begin
                        chk("dado", dado_saida, ref_cel[k]);
                        chk("indice", indice, k);
                    end else begin
                        chk("transferencia_extra", 1, 0);
                    end
                    k++;
                end
            end
        end
        if (!fim) chk("timeout_concluido", 0, 1);
        if (modo == 2) chk("ciclos_parado", stall, 10);

        pronto = 1'b0;
        repeat (3) begin
            passo();
            chk("pos_valido", valido, 0);
            chk("pos_concluido", concluido, 0);
            chk("pos_ocupado", ocupado, 0);
            chk("pos_vazias", vazias, vazias_esp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vazias_esp = 0;
        rst = 1'b1;
        iniciar = 1'b0;
        pronto = 1'b0;
        tabuleiro = '0;

        // Reset then idle
        passo();
        passo();
        chk("rst_dado", dado_saida, 0);
        chk("rst_indice", indice, 0);
        chk("rst_valido", valido, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_concluido", concluido, 0);
        chk("rst_vazias", vazias, 0);
        rst = 1'b0;
        pronto = 1'b1;
        repeat (5) begin
            passo();
            chk("ocioso_valido", valido, 0);
            chk("ocioso_ocupado", ocupado, 0);
        end
        pronto = 1'b0;

        // Full board, no zeros: full speed, then two backpressure patterns
        for (int i = 0; i < CELULAS; i++) cel[i] = (i % 9) + 1;
        varredura(0, 0, -1);
        varredura(1, 0, -1);
        varredura(2, 0, -1);

        // Empty counting: 79 zeros, then an all-zero board
        for (int i = 0; i < CELULAS; i++) cel[i] = 0;
        cel[0] = 7;
        cel[CELULAS-1] = 7;
        varredura(3, 0, -1);
        for (int i = 0; i < CELULAS; i++) cel[i] = 0;
        varredura(0, 0, -1);

        // Snapshot isolation with an ignored start mid-scan
        for (int i = 0; i < CELULAS; i++) cel[i] = (i % 9) + 1;
        varredura(3, 1, -1);

        // Reset mid-scan, then a fresh scan from index 0
        for (int i = 0; i < CELULAS; i++) cel[i] = $urandom_range(0, 15);
        varredura(0, 0, 30);
        varredura(0, 0, -1);

        // Random boards with random backpressure
        repeat (4) begin
            for (int i = 0; i < CELULAS; i++) begin
                cel[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
            end
            varredura(3, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
